// File: rtl/ram_sync_param.sv
// rtl/ram_sync_param.sv - single-port synchronous RAM with power-up clear sweep (optional parity via RAM_PARITY_EN)
module ram_sync_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              init_done
`ifdef RAM_PARITY_EN
    ,
    input  logic              par_inj,
    output logic              par_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   sweep_addr;
    logic [ADDR_W-1:0]   sweep_nxt;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic                accept;
    logic                acc_wr;
    logic                acc_rd;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   rd_word;

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);
    assign accept    = req_valid & req_ready;
    assign acc_wr    = accept & rd_wr;
    assign acc_rd    = accept & ~rd_wr;

    // Stored parity keeps the whole word even; par_inj flips it to model a corrupted cell.
`ifdef RAM_PARITY_EN
    assign wr_word = {(^data_in) ^ par_inj, data_in};
`else
    assign wr_word = data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_nxt;
            sweep_addr <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_addr;
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = wr_word;
        case (state)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_addr;
                mem_wdata = '0;
                sweep_nxt = sweep_addr + 1'b1;
                if (&sweep_addr) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = acc_wr;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Array has no reset: contents are cleared only by the INIT sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[address];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            rsp_valid <= acc_rd;
            if (acc_rd) begin
                data_out <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= acc_rd & (^rd_word);
        end
    end
`endif

endmodule
